// File: rtl/sdram_port_arbiter_pkg.sv
// Shared definitions for the two-master SDRAM burst port arbiter:
// default widths, FSM state encoding and the round-robin pick.
package sdram_port_arbiter_pkg;

  localparam int ADDR_BITS_DEF  = 29;
  localparam int DATA_BITS_DEF  = 64;
  localparam int BURST_BITS_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_CMD  = 2'd1,
    ST_RD_DATA = 2'd2,
    ST_WR      = 2'd3
  } state_e;

  // With both masters requesting, the one that did not own the last burst wins.
  function automatic logic pick_winner(input logic req0, input logic req1,
                                       input logic last_grant);
    return (req0 && req1) ? ~last_grant : req1;
  endfunction

endpackage

// File: rtl/sdram_port_arbiter_cmd_mux.sv
// Pure combinational 2:1 selection of the owning master's Avalon command fields.
module sdram_port_arbiter_cmd_mux #(
  parameter int ADDR_BITS  = 29,
  parameter int DATA_BITS  = 64,
  parameter int BURST_BITS = 8
) (
  input  logic                   sel,
  input  logic [ADDR_BITS-1:0]   m0_address,
  input  logic [BURST_BITS-1:0]  m0_burstcount,
  input  logic                   m0_read,
  input  logic                   m0_write,
  input  logic [DATA_BITS-1:0]   m0_writedata,
  input  logic [DATA_BITS/8-1:0] m0_byteenable,
  input  logic [ADDR_BITS-1:0]   m1_address,
  input  logic [BURST_BITS-1:0]  m1_burstcount,
  input  logic                   m1_read,
  input  logic                   m1_write,
  input  logic [DATA_BITS-1:0]   m1_writedata,
  input  logic [DATA_BITS/8-1:0] m1_byteenable,
  output logic [ADDR_BITS-1:0]   o_address,
  output logic [BURST_BITS-1:0]  o_burstcount,
  output logic                   o_read,
  output logic                   o_write,
  output logic [DATA_BITS-1:0]   o_writedata,
  output logic [DATA_BITS/8-1:0] o_byteenable
);

  assign o_address    = sel ? m1_address    : m0_address;
  assign o_burstcount = sel ? m1_burstcount : m0_burstcount;
  assign o_read       = sel ? m1_read       : m0_read;
  assign o_write      = sel ? m1_write      : m0_write;
  assign o_writedata  = sel ? m1_writedata  : m0_writedata;
  assign o_byteenable = sel ? m1_byteenable : m0_byteenable;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM burst port between two masters;
// grant is held for a full write burst or a read command plus all its beats.
module sdram_port_arbiter
  import sdram_port_arbiter_pkg::*;
#(
  parameter int ADDR_BITS  = ADDR_BITS_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int BURST_BITS = BURST_BITS_DEF
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [ADDR_BITS-1:0]   m0_address,
  input  logic [BURST_BITS-1:0]  m0_burstcount,
  input  logic                   m0_read,
  input  logic                   m0_write,
  input  logic [DATA_BITS-1:0]   m0_writedata,
  input  logic [DATA_BITS/8-1:0] m0_byteenable,
  output logic                   m0_waitrequest,
  output logic [DATA_BITS-1:0]   m0_readdata,
  output logic                   m0_readdatavalid,
  input  logic [ADDR_BITS-1:0]   m1_address,
  input  logic [BURST_BITS-1:0]  m1_burstcount,
  input  logic                   m1_read,
  input  logic                   m1_write,
  input  logic [DATA_BITS-1:0]   m1_writedata,
  input  logic [DATA_BITS/8-1:0] m1_byteenable,
  output logic                   m1_waitrequest,
  output logic [DATA_BITS-1:0]   m1_readdata,
  output logic                   m1_readdatavalid,
  output logic [ADDR_BITS-1:0]   s_address,
  output logic [BURST_BITS-1:0]  s_burstcount,
  output logic                   s_read,
  output logic                   s_write,
  output logic [DATA_BITS-1:0]   s_writedata,
  output logic [DATA_BITS/8-1:0] s_byteenable,
  input  logic                   s_waitrequest,
  input  logic [DATA_BITS-1:0]   s_readdata,
  input  logic                   s_readdatavalid,
  output logic                   grant,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  // Handshake: a command beat transfers on a cycle where s_read or s_write is
  // high and s_waitrequest is low; a read beat transfers whenever readdatavalid
  // is high, with no backpressure from the master.

  localparam logic [BURST_BITS-1:0] ONE = BURST_BITS'(1);

  state_e                  state_q;
  logic                    grant_q;
  logic                    last_grant_q;
  logic                    wr_started_q;
  logic [BURST_BITS-1:0]   beats_left_q;

  logic [ADDR_BITS-1:0]    sel_address;
  logic [BURST_BITS-1:0]   sel_burstcount;
  logic                    sel_read;
  logic                    sel_write;
  logic [DATA_BITS-1:0]    sel_writedata;
  logic [DATA_BITS/8-1:0]  sel_byteenable;
  logic [BURST_BITS-1:0]   first_len;
  logic                    own_wait;
  logic                    rd_beat;
  logic                    wr_accept;
  logic                    req0;
  logic                    req1;
  logic                    winner;
  logic                    win_read;

  sdram_port_arbiter_cmd_mux #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .BURST_BITS(BURST_BITS)
  ) u_cmd_mux (
    .sel          (grant_q),
    .m0_address   (m0_address),
    .m0_burstcount(m0_burstcount),
    .m0_read      (m0_read),
    .m0_write     (m0_write),
    .m0_writedata (m0_writedata),
    .m0_byteenable(m0_byteenable),
    .m1_address   (m1_address),
    .m1_burstcount(m1_burstcount),
    .m1_read      (m1_read),
    .m1_write     (m1_write),
    .m1_writedata (m1_writedata),
    .m1_byteenable(m1_byteenable),
    .o_address    (sel_address),
    .o_burstcount (sel_burstcount),
    .o_read       (sel_read),
    .o_write      (sel_write),
    .o_writedata  (sel_writedata),
    .o_byteenable (sel_byteenable)
  );

  always_comb begin
    req0      = m0_read | m0_write;
    req1      = m1_read | m1_write;
    winner    = pick_winner(req0, req1, last_grant_q);
    win_read  = winner ? m1_read : m0_read;
    first_len = (sel_burstcount == '0) ? ONE : sel_burstcount;

    s_address    = sel_address;
    s_burstcount = sel_burstcount;
    s_writedata  = sel_writedata;
    s_byteenable = sel_byteenable;
    s_read       = (state_q == ST_RD_CMD) & sel_read;
    s_write      = (state_q == ST_WR) & sel_write;
    wr_accept    = s_write & ~s_waitrequest;

    own_wait       = ((state_q == ST_RD_CMD) || (state_q == ST_WR)) ? s_waitrequest : 1'b1;
    m0_waitrequest = grant_q ? 1'b1 : own_wait;
    m1_waitrequest = grant_q ? own_wait : 1'b1;

    // A beat in the command accept cycle is legal and belongs to this burst.
    rd_beat = s_readdatavalid &
              ((state_q == ST_RD_DATA) || ((state_q == ST_RD_CMD) && !s_waitrequest));
    m0_readdata      = s_readdata;
    m1_readdata      = s_readdata;
    m0_readdatavalid = rd_beat & ~grant_q;
    m1_readdatavalid = rd_beat & grant_q;

    grant     = grant_q;
    busy      = (state_q != ST_IDLE);
    state_dbg = state_q;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wr_started_q <= 1'b0;
      beats_left_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0 || req1) begin
            grant_q      <= winner;
            wr_started_q <= 1'b0;
            state_q      <= win_read ? ST_RD_CMD : ST_WR;
          end
        end
        ST_RD_CMD: begin
          if (!s_waitrequest) begin
            if (s_readdatavalid && (first_len == ONE)) begin
              beats_left_q <= '0;
              last_grant_q <= grant_q;
              state_q      <= ST_IDLE;
            end else begin
              beats_left_q <= s_readdatavalid ? (first_len - ONE) : first_len;
              state_q      <= ST_RD_DATA;
            end
          end
        end
        ST_RD_DATA: begin
          if (s_readdatavalid) begin
            beats_left_q <= beats_left_q - ONE;
            if (beats_left_q <= ONE) begin
              last_grant_q <= grant_q;
              state_q      <= ST_IDLE;
            end
          end
        end
        ST_WR: begin
          if (wr_accept) begin
            if (!wr_started_q) begin
              if (first_len == ONE) begin
                last_grant_q <= grant_q;
                state_q      <= ST_IDLE;
              end else begin
                beats_left_q <= first_len - ONE;
                wr_started_q <= 1'b1;
              end
            end else begin
              beats_left_q <= beats_left_q - ONE;
              if (beats_left_q <= ONE) begin
                wr_started_q <= 1'b0;
                last_grant_q <= grant_q;
                state_q      <= ST_IDLE;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: an arbitration vector table plus
// hand-sequenced burst, round-robin, stall and reset scenarios.
module tb_sdram_port_arbiter;

  localparam int AW = 29;
  localparam int DW = 64;
  localparam int BW = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [AW-1:0] m0_address, m1_address, s_address;
  logic [BW-1:0] m0_burstcount, m1_burstcount, s_burstcount;
  logic          m0_read, m0_write, m1_read, m1_write, s_read, s_write;
  logic [DW-1:0] m0_writedata, m1_writedata, s_writedata;
  logic [DW/8-1:0] m0_byteenable, m1_byteenable, s_byteenable;
  logic          m0_waitrequest, m1_waitrequest, s_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata, s_readdata;
  logic          m0_readdatavalid, m1_readdatavalid, s_readdatavalid;
  logic          grant, busy;
  logic [1:0]    state_dbg;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic       m0r, m0w, m1r, m1w;
    logic       exp_grant;
    logic [1:0] exp_state;
  } vec_t;

  vec_t          vecs[9];
  logic [DW-1:0] rd_data[4];
  int            accepts;

  sdram_port_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .m0_address(m0_address), .m0_burstcount(m0_burstcount), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_burstcount(m1_burstcount), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_burstcount(s_burstcount), .s_read(s_read),
    .s_write(s_write), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .grant(grant), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clock = ~clock;

  // Read beats outside a read burst would be illegal slave traffic.
  always @(negedge clock) begin
    if (reset_n && s_readdatavalid && (state_dbg == 2'd0 || state_dbg == 2'd3)) begin
      n_cmp++;
      n_err++;
      $display("FAIL illegal_rdv: readdatavalid seen in state %0d, required never", state_dbg);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
    m0_address = 29'h100; m1_address = 29'h200;
    m0_burstcount = 1; m1_burstcount = 1;
    m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = 8'hFF; m1_byteenable = 8'h0F;
    s_waitrequest = 1; s_readdata = '0; s_readdatavalid = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 0;
    tick();
    reset_n = 1;
  endtask

  initial begin
    vecs[0] = '{1, 0, 0, 0, 0, 2'd1};
    vecs[1] = '{0, 1, 0, 0, 0, 2'd3};
    vecs[2] = '{0, 0, 1, 0, 1, 2'd1};
    vecs[3] = '{0, 0, 0, 1, 1, 2'd3};
    vecs[4] = '{1, 1, 0, 0, 0, 2'd1};
    vecs[5] = '{0, 0, 1, 1, 1, 2'd1};
    vecs[6] = '{1, 0, 0, 1, 0, 2'd1};
    vecs[7] = '{0, 1, 1, 0, 0, 2'd3};
    vecs[8] = '{0, 0, 0, 0, 0, 2'd0};
    rd_data[0] = 64'h1111_0000_AAAA_0001;
    rd_data[1] = 64'h2222_0000_BBBB_0002;
    rd_data[2] = 64'h3333_0000_CCCC_0003;
    rd_data[3] = 64'h4444_0000_DDDD_0004;

    // Reset holds off a pending read; first grant goes to m0 one cycle after release.
    clear_inputs();
    reset_n = 0;
    m0_read = 1;
    tick(); tick();
    settle();
    check("rst_s_read", s_read, 0);
    check("rst_m0_wait", m0_waitrequest, 1);
    check("rst_busy", busy, 0);
    check("rst_grant", grant, 0);
    reset_n = 1;
    tick(); settle();
    check("t1_s_read", s_read, 1);
    check("t1_grant", grant, 0);
    s_waitrequest = 0; s_readdatavalid = 1; s_readdata = 64'hDEAD_BEEF_0000_0001;
    settle();
    check("t1_rdv", m0_readdatavalid, 1);
    check("t1_rdata", m0_readdata, 64'hDEAD_BEEF_0000_0001);
    check("t1_m1_rdv", m1_readdatavalid, 0);
    tick();
    m0_read = 0; s_readdatavalid = 0;
    settle();
    check("t1_idle", busy, 0);

    // Arbitration table, each vector from reset (m0 preferred).
    for (int i = 0; i < 9; i++) begin
      do_reset();
      m0_read = vecs[i].m0r; m0_write = vecs[i].m0w;
      m1_read = vecs[i].m1r; m1_write = vecs[i].m1w;
      settle();
      check($sformatf("v%0d_idle_s_read", i), s_read, 0);
      check($sformatf("v%0d_idle_wait", i), {m0_waitrequest, m1_waitrequest}, 2'b11);
      tick(); settle();
      check($sformatf("v%0d_state", i), state_dbg, vecs[i].exp_state);
      check($sformatf("v%0d_s_read", i), s_read, vecs[i].exp_state == 2'd1);
      check($sformatf("v%0d_s_write", i), s_write, vecs[i].exp_state == 2'd3);
      if (vecs[i].exp_state != 2'd0) begin
        check($sformatf("v%0d_grant", i), grant, vecs[i].exp_grant);
        check($sformatf("v%0d_addr", i), s_address, vecs[i].exp_grant ? 29'h200 : 29'h100);
        check($sformatf("v%0d_other_wait", i),
              vecs[i].exp_grant ? m0_waitrequest : m1_waitrequest, 1);
      end
    end

    // m0 read of 4 with a 2-cycle command stall and a gap in the data.
    do_reset();
    m0_read = 1; m0_burstcount = 4;
    tick(); settle();
    check("t2_s_read", s_read, 1);
    check("t2_stall_wait", m0_waitrequest, 1);
    tick(); settle();
    check("t2_stall2", s_read, 1);
    s_waitrequest = 0;
    settle();
    check("t2_accept_wait", m0_waitrequest, 0);
    check("t2_burst", s_burstcount, 4);
    tick();
    m0_read = 0; s_waitrequest = 1;
    settle();
    check("t2_rd_data_s_read", s_read, 0);
    check("t2_rd_data_wait", m0_waitrequest, 1);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) begin
        settle();
        check("t2_gap_rdv", m0_readdatavalid, 0);
        tick();
      end
      s_readdatavalid = 1; s_readdata = rd_data[b];
      settle();
      check($sformatf("t2_rdv%0d", b), m0_readdatavalid, 1);
      check($sformatf("t2_data%0d", b), m0_readdata, rd_data[b]);
      check($sformatf("t2_m1_rdv%0d", b), m1_readdatavalid, 0);
      check($sformatf("t2_busy%0d", b), busy, 1);
      tick();
      s_readdatavalid = 0;
    end
    settle();
    check("t2_idle_after", busy, 0);

    // Simultaneous writes of 3: m0, one idle cycle, then m1; then round robin to m0.
    do_reset();
    m0_write = 1; m0_burstcount = 3; m1_write = 1; m1_burstcount = 3;
    s_waitrequest = 0;
    tick();
    for (int b = 0; b < 3; b++) begin
      m0_writedata = 64'hA0 + 64'(b);
      settle();
      check($sformatf("t3_m0_grant%0d", b), grant, 0);
      check($sformatf("t3_m0_s_write%0d", b), s_write, 1);
      check($sformatf("t3_m0_wdata%0d", b), s_writedata, 64'hA0 + 64'(b));
      check($sformatf("t3_m1_wait%0d", b), m1_waitrequest, 1);
      tick();
    end
    m0_write = 0;
    settle();
    check("t3_gap_busy", busy, 0);
    check("t3_gap_s_write", s_write, 0);
    tick();
    for (int b = 0; b < 3; b++) begin
      m1_writedata = 64'hB0 + 64'(b);
      settle();
      check($sformatf("t3_m1_grant%0d", b), grant, 1);
      check($sformatf("t3_m1_wdata%0d", b), s_writedata, 64'hB0 + 64'(b));
      check($sformatf("t3_m1_be%0d", b), s_byteenable, 8'h0F);
      tick();
    end
    m1_write = 0;
    settle();
    check("t3_m1_done", busy, 0);
    m0_write = 1; m0_burstcount = 1; m1_write = 1; m1_burstcount = 1;
    tick(); settle();
    check("t3_rr_grant", grant, 0);
    tick();
    m0_write = 0; m1_write = 0;
    settle();
    check("t3_rr_done", busy, 0);

    // m1 write of 8 with write dropped for two cycles; m0 read waits throughout.
    m1_write = 1; m1_burstcount = 8; m0_read = 1; m0_burstcount = 2;
    tick();
    accepts = 0;
    for (int c = 0; c < 10; c++) begin
      m1_write = !(c == 2 || c == 3);
      settle();
      check($sformatf("t4_grant%0d", c), grant, 1);
      check($sformatf("t4_m0_wait%0d", c), m0_waitrequest, 1);
      if (s_write && !s_waitrequest) accepts++;
      tick();
    end
    m1_write = 0;
    settle();
    check("t4_accepts", accepts, 8);
    check("t4_idle", busy, 0);

    // m0 read of 2 now wins; m1 write pending is held off until beat 2.
    m1_write = 1; m1_burstcount = 1;
    tick(); settle();
    check("t5_grant", grant, 0);
    check("t5_s_read", s_read, 1);
    tick();
    m0_read = 0;
    for (int c = 0; c < 3; c++) begin
      s_readdatavalid = (c != 1);
      s_readdata = 64'hC0 + 64'(c);
      settle();
      check($sformatf("t5_m1_wait%0d", c), m1_waitrequest, 1);
      check($sformatf("t5_busy%0d", c), busy, 1);
      check($sformatf("t5_m0_rdv%0d", c), m0_readdatavalid, c != 1);
      tick();
    end
    s_readdatavalid = 0;
    settle();
    check("t5_gap", busy, 0);
    tick(); settle();
    check("t5_m1_grant", grant, 1);
    check("t5_m1_s_write", s_write, 1);
    check("t5_m1_wait", m1_waitrequest, 0);
    tick();
    m1_write = 0;
    settle();
    check("t5_done", busy, 0);

    // Reset during RD_DATA with 2 beats outstanding, then a normal m1 grant.
    m0_read = 1; m0_burstcount = 3;
    tick(); tick();
    m0_read = 0; s_readdatavalid = 1; s_readdata = 64'h55;
    settle();
    check("t6_beat1", m0_readdatavalid, 1);
    tick();
    s_readdatavalid = 0; reset_n = 0;
    settle();
    check("t6_busy_pre", busy, 1);
    tick(); settle();
    check("t6_busy", busy, 0);
    check("t6_grant", grant, 0);
    check("t6_state", state_dbg, 0);
    reset_n = 1; m1_write = 1; m1_burstcount = 1;
    tick(); settle();
    check("t6_m1_grant", grant, 1);
    check("t6_m1_s_write", s_write, 1);
    tick();
    m1_write = 0;
    settle();
    check("t6_m1_done", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
